// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and framing limits.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int MIN_DATA_SIZE  = 5;
    localparam int MAX_DATA_SIZE  = 8;
    localparam int MIN_BIT_PERIOD = 2;

endpackage

// File: rtl/tx_timer.sv
// Bit-period timer: counts 1..bit_period while enabled and flags the last cycle of each bit.
module tx_timer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        enable,
    input  logic [13:0] bit_period,
    output logic        bit_tick
);

    logic [13:0] cnt;

    // enable is the next-cycle busy flag, so the first cycle of a bit already reads 1
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt >= bit_period) begin
            cnt <= 14'd1;
        end else begin
            cnt <= cnt + 14'd1;
        end
    end

    assign bit_tick = (cnt != '0) && (cnt == bit_period);

endmodule

// File: rtl/tx_block.sv
// UART transmitter: one-entry holding buffer feeding a start/data/stop serialiser.
module tx_block
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  tx_data,
    input  logic        load_data,
    input  logic [13:0] bit_period,
    input  logic [3:0]  data_size,
    output logic        serial_out,
    output logic        buffer_empty,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        overrun_error
);

    function automatic logic [3:0] sat_data_size(input logic [3:0] ds);
        if (ds < 4'(MIN_DATA_SIZE) || ds > 4'(MAX_DATA_SIZE)) begin
            return 4'(MAX_DATA_SIZE);
        end
        return ds;
    endfunction

    function automatic logic [13:0] sat_bit_period(input logic [13:0] bp);
        if (bp < 14'(MIN_BIT_PERIOD)) begin
            return 14'(MIN_BIT_PERIOD);
        end
        return bp;
    endfunction

    tx_state_t   state;
    logic [7:0]  hold_buf;
    logic [7:0]  shreg;
    logic [13:0] bp_lat;
    logic [3:0]  ds_lat;
    logic [3:0]  bit_cnt;
    logic        stop_cnt;
    logic        bit_tick;
    logic        last_stop;
    logic        end_frame;
    logic        start_frame;
    logic        accept;
    logic        shift_en;
    logic        timer_en;

    assign last_stop   = (stop_cnt == 1'(STOP_BITS - 1));
    assign end_frame   = (state == STOP) && bit_tick && last_stop;
    assign start_frame = !buffer_empty && ((state == IDLE) || end_frame);
    assign accept      = load_data && buffer_empty;
    assign shift_en    = (state == DATA) && bit_tick;
    assign timer_en    = start_frame || ((state != IDLE) && !end_frame);

    tx_timer u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (timer_en),
        .bit_period (bp_lat),
        .bit_tick   (bit_tick)
    );

    // Payload registers carry no reset; control below decides when they matter
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_buf <= tx_data;
        end
        if (start_frame) begin
            shreg <= hold_buf;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            serial_out    <= 1'b1;
            buffer_empty  <= 1'b1;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
            overrun_error <= 1'b0;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            bp_lat        <= 14'(MIN_BIT_PERIOD);
            ds_lat        <= 4'(MAX_DATA_SIZE);
        end else begin
            tx_done <= end_frame;

            // accept needs an empty buffer and start_frame a full one, so they never collide
            if (accept) begin
                buffer_empty  <= 1'b0;
                overrun_error <= 1'b0;
            end else if (load_data) begin
                overrun_error <= 1'b1;
            end

            if (start_frame) begin
                buffer_empty <= 1'b1;
                bp_lat       <= sat_bit_period(bit_period);
                ds_lat       <= sat_data_size(data_size);
                state        <= START;
                serial_out   <= 1'b0;
                tx_busy      <= 1'b1;
                bit_cnt      <= '0;
                stop_cnt     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        serial_out <= 1'b1;
                        tx_busy    <= 1'b0;
                    end
                    START: begin
                        if (bit_tick) begin
                            state      <= DATA;
                            serial_out <= shreg[0];
                            bit_cnt    <= 4'd1;
                        end
                    end
                    DATA: begin
                        if (bit_tick) begin
                            if (bit_cnt == ds_lat) begin
                                state      <= STOP;
                                serial_out <= 1'b1;
                            end else begin
                                serial_out <= shreg[1];
                                bit_cnt    <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (bit_tick) begin
                            if (last_stop) begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end else begin
                                stop_cnt <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_block.sv
// Self-checking bench for tx_block: vector table, corner sequences and randomized frames.
module tb_tx_block;

    localparam int SB = 1;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  tx_data;
    logic        load_data;
    logic [13:0] bit_period;
    logic [3:0]  data_size;
    logic        serial_out;
    logic        buffer_empty;
    logic        tx_busy;
    logic        tx_done;
    logic        overrun_error;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tx_block #(.STOP_BITS(SB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_data       (tx_data),
        .load_data     (load_data),
        .bit_period    (bit_period),
        .data_size     (data_size),
        .serial_out    (serial_out),
        .buffer_empty  (buffer_empty),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .overrun_error (overrun_error)
    );

    typedef struct {
        logic [7:0] data;
        int         ds;
        int         bp;
        int         len;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        int         ds;
        int         bp;
    } frm_t;

    vec_t vecs[8];
    frm_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int eff_ds(input int d);
        return (d >= 5 && d <= 8) ? d : 8;
    endfunction

    function automatic int eff_bp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    // Line level expected idx cycles after the start bit begins
    function automatic logic exp_bit(input logic [7:0] b, input int ds, input int bp, input int idx);
        int slot;
        slot = idx / bp;
        if (slot == 0) return 1'b0;
        if (slot <= ds) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] b, input int ds, input int bp, input int exp_len);
        int eds, ebp, errs, busy_errs, done_at, done_cnt;
        eds = eff_ds(ds);
        ebp = eff_bp(bp);
        tx_data    = b;
        data_size  = ds[3:0];
        bit_period = bp[13:0];
        load_data  = 1'b1;
        tick();
        load_data = 1'b0;
        tx_data   = 8'($urandom);
        @(negedge clk);
        check({name, " line_before_start"}, int'(serial_out), 1);
        check({name, " buffer_full"}, int'(buffer_empty), 0);
        tick();
        data_size  = 4'($urandom_range(0, 15));
        bit_period = 14'($urandom_range(0, 20));
        errs = 0; busy_errs = 0; done_at = -1; done_cnt = 0;
        for (int i = 0; i <= exp_len + 2; i++) begin
            @(negedge clk);
            if (i < exp_len && serial_out !== exp_bit(b, eds, ebp, i)) errs++;
            if (i < exp_len && tx_busy !== 1'b1) busy_errs++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            tick();
        end
        check({name, " waveform_errs"}, errs, 0);
        check({name, " busy_errs"}, busy_errs, 0);
        check({name, " done_cycle"}, done_at, exp_len);
        check({name, " done_count"}, done_cnt, 1);
        check({name, " idle_after"}, int'(tx_busy), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 8, 10, 100};
        vecs[1] = '{8'hFF, 5, 10, 70};
        vecs[2] = '{8'hE0, 5, 3, 21};
        vecs[3] = '{8'h3C, 7, 3, 27};
        vecs[4] = '{8'h81, 12, 1, 20};
        vecs[5] = '{8'h55, 4, 0, 20};
        vecs[6] = '{8'hE0, 6, 4, 32};
        vecs[7] = '{8'h13, 5, 2, 14};

        // Reset state
        n_rst = 1'b0; load_data = 1'b0; tx_data = 8'h00;
        bit_period = 14'd10; data_size = 4'd8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst serial_out", int'(serial_out), 1);
        check("rst buffer_empty", int'(buffer_empty), 1);
        check("rst tx_busy", int'(tx_busy), 0);
        check("rst tx_done", int'(tx_done), 0);
        check("rst overrun", int'(overrun_error), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].ds, vecs[v].bp, vecs[v].len);
        end

        // Back-to-back frames: second load while the first frame is on the line
        begin : b2b
            int errs, busy_errs, dcnt, d1, d2;
            errs = 0; busy_errs = 0; dcnt = 0; d1 = -1; d2 = -1;
            tx_data = 8'h12; bit_period = 14'd4; data_size = 4'd8; load_data = 1'b1;
            tick();
            load_data = 1'b0;
            tick();
            for (int i = 0; i <= 82; i++) begin
                load_data = (i == 5);
                if (i == 5) tx_data = 8'h34;
                @(negedge clk);
                if (i < 40 && serial_out !== exp_bit(8'h12, 8, 4, i)) errs++;
                if (i >= 40 && i < 80 && serial_out !== exp_bit(8'h34, 8, 4, i - 40)) errs++;
                if (i < 80 && tx_busy !== 1'b1) busy_errs++;
                if (tx_done === 1'b1) begin
                    if (dcnt == 0) d1 = i;
                    else d2 = i;
                    dcnt++;
                end
                tick();
            end
            load_data = 1'b0;
            check("b2b waveform_errs", errs, 0);
            check("b2b busy_gap", busy_errs, 0);
            check("b2b done_count", dcnt, 2);
            check("b2b done1", d1, 40);
            check("b2b done2", d2, 80);
        end

        // Overrun: third load with the buffer still holding the second byte
        begin : ovr
            int w;
            tx_data = 8'h11; bit_period = 14'd2; data_size = 4'd5; load_data = 1'b1;
            tick();
            load_data = 1'b0;
            tick();
            tx_data = 8'h22; load_data = 1'b1;
            tick();
            load_data = 1'b0;
            @(negedge clk);
            check("ovr buf_full_after_2nd", int'(buffer_empty), 0);
            check("ovr no_err_after_2nd", int'(overrun_error), 0);
            tick();
            tx_data = 8'h33; load_data = 1'b1;
            tick();
            load_data = 1'b0;
            @(negedge clk);
            check("ovr err_after_3rd", int'(overrun_error), 1);
            check("ovr buf_still_full", int'(buffer_empty), 0);
            w = 0;
            while (buffer_empty !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("ovr drain_seen", int'(buffer_empty), 1);
            check("ovr err_sticky", int'(overrun_error), 1);
            @(posedge clk); #1;
            tx_data = 8'h44; load_data = 1'b1;
            tick();
            load_data = 1'b0;
            @(negedge clk);
            check("ovr err_cleared", int'(overrun_error), 0);
            w = 0;
            while (!(tx_busy === 1'b0 && buffer_empty === 1'b1) && w < 200) begin
                @(negedge clk);
                w++;
            end
            check("ovr all_drained", int'(tx_busy === 1'b0 && buffer_empty === 1'b1), 1);
            tick();
        end

        // Reset in the middle of a data bit
        tx_data = 8'h00; bit_period = 14'd10; data_size = 4'd8; load_data = 1'b1;
        tick();
        load_data = 1'b0;
        tick();
        repeat (35) tick();
        @(negedge clk);
        check("rstmid data_low", int'(serial_out), 0);
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        check("rstmid serial_high", int'(serial_out), 1);
        check("rstmid busy_low", int'(tx_busy), 0);
        check("rstmid buf_empty", int'(buffer_empty), 1);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        run_frame("post_rst", 8'hC3, 8, 3, 30);

        // Randomized frames checked against the frame-level model
        load_data = 1'b0;
        fork
            begin : drv
                int w, gap, ds, bp;
                logic [7:0] b;
                for (int k = 0; k < 25; k++) begin
                    @(negedge clk);
                    w = 0;
                    while (buffer_empty !== 1'b1 && w < 2000) begin
                        @(negedge clk);
                        w++;
                    end
                    if (buffer_empty !== 1'b1) begin
                        check("rand drv_wait", 0, 1);
                        break;
                    end
                    gap = $urandom_range(0, 3);
                    repeat (gap) @(negedge clk);
                    @(posedge clk); #1;
                    b  = 8'($urandom);
                    ds = $urandom_range(3, 10);
                    bp = $urandom_range(1, 6);
                    tx_data = b; data_size = ds[3:0]; bit_period = bp[13:0];
                    load_data = 1'b1;
                    exp_q.push_back('{b, eff_ds(ds), eff_bp(bp)});
                    @(posedge clk); #1;
                    load_data = 1'b0;
                end
            end
            begin : mon
                int w, errs, len;
                frm_t f;
                @(negedge clk);
                for (int k = 0; k < 25; k++) begin
                    w = 0;
                    while (serial_out !== 1'b0 && w < 3000) begin
                        @(negedge clk);
                        w++;
                    end
                    if (serial_out !== 1'b0 || exp_q.size() == 0) begin
                        check("rand frame_start", 0, 1);
                        break;
                    end
                    f = exp_q.pop_front();
                    len = (1 + f.ds + SB) * f.bp;
                    errs = 0;
                    for (int i = 0; i < len; i++) begin
                        if (i > 0) @(negedge clk);
                        if (serial_out !== exp_bit(f.b, f.ds, f.bp, i)) errs++;
                    end
                    @(negedge clk);
                    check($sformatf("rand%0d waveform_errs", k), errs, 0);
                    check($sformatf("rand%0d done", k), int'(tx_done), 1);
                end
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
